// File: rtl/avalon_pkg.sv
// Shared types and constants for the Avalon SDRAM responder and the
// checkers of the bus masters that talk to it.
package avalon_pkg;

    typedef enum logic {INIT, READY} resp_state_t;

    typedef logic [15:0] data_t;

    localparam data_t DEFAULT_OOR_DATA = 16'hDEAD;

endpackage

// File: rtl/read_latency_pipe.sv
// Fixed-latency read return path: a LATENCY-deep {valid, data} shift register.
// Each stage only takes new data when a valid word passes, so readdata holds.
module read_latency_pipe
    import avalon_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  in_valid,
    input  data_t in_data,
    output logic  out_valid,
    output data_t out_data
);

    logic  valid_q [LATENCY];
    data_t data_q  [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) data_q[0] <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/avalon_sdram_responder.sv
// Avalon-MM word-addressed 16-bit memory slave with self-initialisation,
// waitrequest back-pressure and pipelined fixed-latency reads.
module avalon_sdram_responder
    import avalon_pkg::*;
#(
    parameter int    DEPTH       = 1024,
    parameter int    LATENCY     = 3,
    parameter int    MAX_PENDING = 4,
    parameter data_t INIT_XOR    = 16'h0000,
    parameter data_t OOR_DATA    = DEFAULT_OOR_DATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] address,
    input  logic [1:0]  byteenable,
    input  logic [15:0] writedata,
    output logic        waitrequest,
    output logic        readdatavalid,
    output logic [15:0] readdata,
    output logic        init_done,
    output logic        protocol_error
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(MAX_PENDING + 1);

    resp_state_t   state;
    logic [AW-1:0] init_cnt;
    logic [PW-1:0] pending;
    data_t         mem [DEPTH];

    logic  in_range;
    logic  accept;
    logic  wr_accept;
    logic  rd_accept;
    logic  both_req;
    data_t rd_word;

    assign in_range  = address < 32'(DEPTH);
    assign accept    = chipselect & (~read_n | ~write_n) & ~waitrequest;
    assign wr_accept = accept & ~write_n;
    // A simultaneous read/write keeps the write and drops the read.
    assign rd_accept = accept & ~read_n & write_n;
    assign both_req  = accept & ~read_n & ~write_n;
    assign rd_word   = in_range ? mem[address[AW-1:0]] : OOR_DATA;

    assign waitrequest = (state == INIT)
                       | ((pending == PW'(MAX_PENDING)) & ~readdatavalid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= INIT;
            init_cnt       <= '0;
            init_done      <= 1'b0;
            protocol_error <= 1'b0;
            pending        <= '0;
        end else begin
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == AW'(DEPTH - 1)) begin
                    state     <= READY;
                    init_done <= 1'b1;
                end
            end
            if (both_req) protocol_error <= 1'b1;
            if (rd_accept & ~readdatavalid)
                pending <= pending + 1'b1;
            else if (~rd_accept & readdatavalid)
                pending <= pending - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_cnt] <= data_t'(init_cnt) ^ INIT_XOR;
        end else if (wr_accept & in_range) begin
            if (byteenable[0]) mem[address[AW-1:0]][7:0]  <= writedata[7:0];
            if (byteenable[1]) mem[address[AW-1:0]][15:8] <= writedata[15:8];
        end
    end

    read_latency_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_accept),
        .in_data   (rd_word),
        .out_valid (readdatavalid),
        .out_data  (readdata)
    );

endmodule
